// File: rtl/mem_bus_ctrl_pkg.sv
// Shared bus definitions for the processor-side memory initiator.
// Bus command encoding, address width and requester owner identifiers.
package mem_bus_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load table: lowest-free allocation, CAM lookup/free, valid count.
// A matching return frees its entry on the same edge a new load may claim it.
module mem_tag_table #(
    parameter int NUM_OUT = 4,
    parameter int TAG_W   = 4,
    localparam int CNT_W  = $clog2(NUM_OUT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output logic             hit_owner,
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic             alloc_owner,
    output logic [CNT_W-1:0] count
);

    logic [NUM_OUT-1:0] valid;
    logic [NUM_OUT-1:0] free_vec;
    logic [NUM_OUT-1:0] after_free;
    logic [NUM_OUT-1:0] alloc_vec;
    logic               placed;
    logic [TAG_W-1:0]   tag   [NUM_OUT];
    logic               owner [NUM_OUT];

    always_comb begin
        hit       = 1'b0;
        hit_owner = 1'b0;
        free_vec  = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (!hit && valid[i] && lookup_tag != '0 && tag[i] == lookup_tag) begin
                hit         = 1'b1;
                hit_owner   = owner[i];
                free_vec[i] = 1'b1;
            end
        end
    end

    // Allocation sees the table after this edge's free, so a freed slot is reusable at once.
    always_comb begin
        after_free = valid & ~free_vec;
        alloc_vec  = '0;
        placed     = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (alloc_en && !placed && !after_free[i]) begin
                alloc_vec[i] = 1'b1;
                placed       = 1'b1;
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            count = count + CNT_W'(valid[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else begin
            valid <= after_free | alloc_vec;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_OUT; i++) begin
            if (alloc_vec[i]) begin
                tag[i]   <= alloc_tag;
                owner[i] <= alloc_owner;
            end
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Tagged memory bus initiator: round-robin arbitration between icache and dcache,
// a retrying issue register, and routing of tagged load returns to their owners.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int NUM_OUT = 4,
    parameter int TAG_W   = 4,
    localparam int CNT_W  = $clog2(NUM_OUT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ic_req_valid,
    input  logic [XLEN-1:0]  ic_req_addr,
    output logic             ic_req_ready,
    input  logic             dc_req_valid,
    input  logic [1:0]       dc_req_cmd,
    input  logic [XLEN-1:0]  dc_req_addr,
    input  logic [63:0]      dc_req_data,
    output logic             dc_req_ready,
    output logic [1:0]       proc2mem_command,
    output logic [XLEN-1:0]  proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [63:0]      mem2proc_data,
    input  logic [TAG_W-1:0] mem2proc_tag,
    output logic             ic_rsp_valid,
    output logic [63:0]      ic_rsp_data,
    output logic             dc_rsp_valid,
    output logic [63:0]      dc_rsp_data,
    output logic             store_done,
    output logic [CNT_W-1:0] num_outstanding,
    output logic             tag_err
);

    logic             ir_valid;
    logic [1:0]       ir_cmd;
    logic [XLEN-1:0]  ir_addr;
    logic [63:0]      ir_data;
    logic             ir_owner;
    logic             rr_ic_prio;
    logic             accepted, can_take, ir_load, load_ok;
    logic             hit, hit_owner, alloc_en;
    logic [CNT_W-1:0] table_count;
    logic             dc_is_load, dc_is_store;
    logic             ic_ok, dc_ok, grant_ic, grant_dc;
    logic [63:0]      rsp_data;

    assign accepted        = ir_valid && (mem2proc_response != '0);
    assign can_take        = !ir_valid || accepted;
    assign ir_load         = ir_valid && (ir_cmd == BUS_LOAD);
    assign alloc_en        = accepted && (ir_cmd == BUS_LOAD);
    assign num_outstanding = table_count + CNT_W'(ir_load);
    assign load_ok         = (num_outstanding < CNT_W'(NUM_OUT)) || hit;
    assign dc_is_load      = (dc_req_cmd == BUS_LOAD);
    assign dc_is_store     = (dc_req_cmd == BUS_STORE);

    // Readies are held low during reset so every output reads 0 asynchronously.
    always_comb begin
        ic_ok    = reset && ic_req_valid && can_take && load_ok;
        dc_ok    = reset && dc_req_valid && can_take && (dc_is_store || (dc_is_load && load_ok));
        grant_ic = ic_ok && (!dc_ok || rr_ic_prio);
        grant_dc = dc_ok && !grant_ic;
    end

    assign ic_req_ready     = grant_ic;
    assign dc_req_ready     = grant_dc;
    assign proc2mem_command = ir_valid ? ir_cmd  : BUS_NONE;
    assign proc2mem_addr    = ir_valid ? ir_addr : '0;
    assign proc2mem_data    = ir_valid ? ir_data : '0;
    assign ic_rsp_data      = rsp_data;
    assign dc_rsp_data      = rsp_data;

    mem_tag_table #(
        .NUM_OUT (NUM_OUT),
        .TAG_W   (TAG_W)
    ) u_tag_table (
        .clock       (clock),
        .reset       (reset),
        .lookup_tag  (mem2proc_tag),
        .hit         (hit),
        .hit_owner   (hit_owner),
        .alloc_en    (alloc_en),
        .alloc_tag   (mem2proc_response),
        .alloc_owner (ir_owner),
        .count       (table_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir_valid     <= 1'b0;
            rr_ic_prio   <= 1'b0;
            store_done   <= 1'b0;
            ic_rsp_valid <= 1'b0;
            dc_rsp_valid <= 1'b0;
            rsp_data     <= '0;
            tag_err      <= 1'b0;
        end else begin
            if (grant_ic || grant_dc) begin
                ir_valid   <= 1'b1;
                rr_ic_prio <= grant_dc;
            end else if (accepted) begin
                ir_valid <= 1'b0;
            end
            store_done   <= accepted && (ir_cmd == BUS_STORE);
            ic_rsp_valid <= hit && (hit_owner == OWNER_IC);
            dc_rsp_valid <= hit && (hit_owner == OWNER_DC);
            if (hit) begin
                rsp_data <= mem2proc_data;
            end
            if (mem2proc_tag != '0 && !hit) begin
                tag_err <= 1'b1;
            end
        end
    end

    // Payload is only observed while ir_valid, so it carries no reset.
    always_ff @(posedge clock) begin
        if (grant_ic) begin
            ir_cmd   <= BUS_LOAD;
            ir_addr  <= ic_req_addr;
            ir_data  <= '0;
            ir_owner <= OWNER_IC;
        end else if (grant_dc) begin
            ir_cmd   <= dc_req_cmd;
            ir_addr  <= dc_req_addr;
            ir_data  <= dc_is_store ? dc_req_data : '0;
            ir_owner <= OWNER_DC;
        end
    end

endmodule
